// File: rtl/wb_stage.sv
// Writeback stage of the RV32 pipeline: MEM/WB register, writeback select,
// regfile write port, WB->EX forwarding, sticky halt and retired-instruction count.
module wb_stage #(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in_wb,
  input  logic                     flush_in_wb,
  input  logic                     halt_in_wb,
  input  logic [31:0]              PC_in_wb,
  input  logic [31:0]              Instr_in_wb,
  input  logic [31:0]              ALUOutput_in_wb,
  input  logic [31:0]              LoadExtended_in_wb,
  input  logic [31:0]              Imm_in_wb,
  input  logic [1:0]               WBSel_in_wb,
  input  logic                     RWrEn_in_wb,
  output logic                     RWrEn_out_wb,
  output logic [4:0]               Rdst_out_wb,
  output logic [31:0]              RWrdata_out_wb,
  output logic                     fwd_valid_out_wb,
  output logic [4:0]               fwd_rd_out_wb,
  output logic [31:0]              fwd_data_out_wb,
  output logic                     halt_out_wb,
  output logic [INSTRET_WIDTH-1:0] instret_out_wb
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     valid_q;
  logic                     halt_q;
  logic                     rwren_q;
  logic [4:0]               rd_q;
  logic [1:0]               wbsel_q;
  logic [31:0]              pc_q;
  logic [31:0]              alu_q;
  logic [31:0]              load_q;
  logic [31:0]              imm_q;
  logic [INSTRET_WIDTH-1:0] instret_q;

  logic        halting;
  logic        freeze;
  logic        retire;
  logic        we;
  logic [31:0] wb_data;
  logic        unused_instr_bits;

  // Only the rd field of the instruction word matters here.
  assign unused_instr_bits = ^{Instr_in_wb[31:12], Instr_in_wb[6:0]};

  function automatic logic [31:0] wb_mux(
    input logic [1:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] pc,
    input logic [31:0] load,
    input logic [31:0] imm
  );
    logic [31:0] r;
    case (sel)
      2'b00:   r = alu;
      2'b01:   r = pc + 32'd4;
      2'b10:   r = load;
      2'b11:   r = imm;
      default: r = alu;
    endcase
    return r;
  endfunction

  assign halting = valid_q & halt_q;
  // The register stops accepting inputs as soon as halt is visible, so the
  // halting instruction stays parked in WB.
  assign freeze  = (state == HALTED) | halting;
  assign retire  = valid_q & ~halt_q & (state == RUN);
  assign we      = retire & ~rwren_q & (rd_q != 5'd0);
  assign wb_data = wb_mux(wbsel_q, alu_q, pc_q, load_q, imm_q);

  assign RWrEn_out_wb     = ~we;
  assign Rdst_out_wb      = rd_q;
  assign RWrdata_out_wb   = wb_data;
  assign fwd_valid_out_wb = we;
  assign fwd_rd_out_wb    = rd_q;
  assign fwd_data_out_wb  = wb_data;
  assign halt_out_wb      = (state == HALTED) | halting;
  assign instret_out_wb   = instret_q;

  // Next-state logic: HALTED is sticky until reset.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (halting) begin
          state_next = HALTED;
        end else begin
          state_next = RUN;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // State register, MEM/WB pipeline register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      valid_q   <= 1'b0;
      halt_q    <= 1'b0;
      rwren_q   <= 1'b0;
      rd_q      <= 5'd0;
      wbsel_q   <= 2'b00;
      pc_q      <= 32'd0;
      alu_q     <= 32'd0;
      load_q    <= 32'd0;
      imm_q     <= 32'd0;
      instret_q <= '0;
    end else begin
      state <= state_next;
      if (!freeze) begin
        valid_q <= valid_in_wb & ~flush_in_wb;
        halt_q  <= halt_in_wb & valid_in_wb & ~flush_in_wb;
        rwren_q <= RWrEn_in_wb;
        rd_q    <= Instr_in_wb[11:7];
        wbsel_q <= WBSel_in_wb;
        pc_q    <= PC_in_wb;
        alu_q   <= ALUOutput_in_wb;
        load_q  <= LoadExtended_in_wb;
        imm_q   <= Imm_in_wb;
      end
      if (retire) begin
        instret_q <= instret_q + INSTRET_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a reference model computes each instruction's
// expected WB-cycle outputs into a scoreboard queue, popped one cycle later.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in_wb, flush_in_wb, halt_in_wb;
  logic [31:0] PC_in_wb, Instr_in_wb, ALUOutput_in_wb, LoadExtended_in_wb, Imm_in_wb;
  logic [1:0]  WBSel_in_wb;
  logic        RWrEn_in_wb;
  logic        RWrEn_out_wb;
  logic [4:0]  Rdst_out_wb;
  logic [31:0] RWrdata_out_wb;
  logic        fwd_valid_out_wb;
  logic [4:0]  fwd_rd_out_wb;
  logic [31:0] fwd_data_out_wb;
  logic        halt_out_wb;
  logic [31:0] instret_out_wb;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        halt;
    logic [31:0] instret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt_m = 32'd0;
  logic        halted_m = 1'b0;

  wb_stage #(.INSTRET_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in_wb(valid_in_wb), .flush_in_wb(flush_in_wb), .halt_in_wb(halt_in_wb),
    .PC_in_wb(PC_in_wb), .Instr_in_wb(Instr_in_wb), .ALUOutput_in_wb(ALUOutput_in_wb),
    .LoadExtended_in_wb(LoadExtended_in_wb), .Imm_in_wb(Imm_in_wb),
    .WBSel_in_wb(WBSel_in_wb), .RWrEn_in_wb(RWrEn_in_wb),
    .RWrEn_out_wb(RWrEn_out_wb), .Rdst_out_wb(Rdst_out_wb), .RWrdata_out_wb(RWrdata_out_wb),
    .fwd_valid_out_wb(fwd_valid_out_wb), .fwd_rd_out_wb(fwd_rd_out_wb),
    .fwd_data_out_wb(fwd_data_out_wb), .halt_out_wb(halt_out_wb),
    .instret_out_wb(instret_out_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one instruction, predict its WB-cycle outputs, then compare after the edge.
  task automatic step(input string tag, input logic v, input logic f, input logic h,
                      input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] imm,
                      input logic rwren);
    exp_t e;
    logic vq, hq;
    valid_in_wb = v; flush_in_wb = f; halt_in_wb = h; PC_in_wb = pc;
    Instr_in_wb = {20'hABCDE, rd, 7'h33}; WBSel_in_wb = sel; ALUOutput_in_wb = alu;
    LoadExtended_in_wb = ld; Imm_in_wb = imm; RWrEn_in_wb = rwren;
    e.rd = rd; e.instret = cnt_m;
    case (sel)
      2'b00:   e.data = alu;
      2'b01:   e.data = pc + 32'd4;
      2'b10:   e.data = ld;
      default: e.data = imm;
    endcase
    if (halted_m) begin
      e.we = 1'b0; e.halt = 1'b1;
    end else begin
      vq = v & ~f;
      hq = h & vq;
      e.we = vq & ~hq & ~rwren & (rd != 5'd0);
      e.halt = hq;
      if (vq && !hq) cnt_m = cnt_m + 32'd1;
      if (hq) halted_m = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check({tag, ".rwren"}, {31'd0, RWrEn_out_wb}, {31'd0, ~e.we});
    check({tag, ".fwd_valid"}, {31'd0, fwd_valid_out_wb}, {31'd0, e.we});
    check({tag, ".halt"}, {31'd0, halt_out_wb}, {31'd0, e.halt});
    check({tag, ".instret"}, instret_out_wb, e.instret);
    check({tag, ".no_x"}, {31'd0, $isunknown({Rdst_out_wb, RWrdata_out_wb,
                                             fwd_rd_out_wb, fwd_data_out_wb})}, 32'd0);
    if (e.we) begin
      check({tag, ".rdst"}, {27'd0, Rdst_out_wb}, {27'd0, e.rd});
      check({tag, ".data"}, RWrdata_out_wb, e.data);
      check({tag, ".fwd_rd"}, {27'd0, fwd_rd_out_wb}, {27'd0, e.rd});
      check({tag, ".fwd_data"}, fwd_data_out_wb, e.data);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_m = 32'd0; halted_m = 1'b0;
    check({tag, ".rwren"}, {31'd0, RWrEn_out_wb}, 32'd1);
    check({tag, ".rdst"}, {27'd0, Rdst_out_wb}, 32'd0);
    check({tag, ".data"}, RWrdata_out_wb, 32'd0);
    check({tag, ".fwd_valid"}, {31'd0, fwd_valid_out_wb}, 32'd0);
    check({tag, ".fwd_rd"}, {27'd0, fwd_rd_out_wb}, 32'd0);
    check({tag, ".fwd_data"}, fwd_data_out_wb, 32'd0);
    check({tag, ".halt"}, {31'd0, halt_out_wb}, 32'd0);
    check({tag, ".instret"}, instret_out_wb, 32'd0);
  endtask

  initial begin
    valid_in_wb = 1'b1; flush_in_wb = 1'b0; halt_in_wb = 1'b1; PC_in_wb = 32'd0;
    Instr_in_wb = 32'd0; ALUOutput_in_wb = 32'd0; LoadExtended_in_wb = 32'd0;
    Imm_in_wb = 32'd0; WBSel_in_wb = 2'b00; RWrEn_in_wb = 1'b0;
    #2;
    do_reset("reset");

    //   tag         v     f     h     pc             rd     sel    alu            ld             imm            rwren
    step("alu",      1'b1, 1'b0, 1'b0, 32'h0000_0000, 5'd5,  2'b00, 32'h0000_1234, 32'd0,         32'd0,         1'b0);
    step("pc4",      1'b1, 1'b0, 1'b0, 32'h0000_0100, 5'd6,  2'b01, 32'h0000_0055, 32'd0,         32'd0,         1'b0);
    step("load",     1'b1, 1'b0, 1'b0, 32'h0000_0104, 5'd8,  2'b10, 32'h0000_0055, 32'hFFFF_FF80, 32'd0,         1'b0);
    step("imm",      1'b1, 1'b0, 1'b0, 32'h0000_0108, 5'd31, 2'b11, 32'h0000_0055, 32'd0,         32'hABCD_E000, 1'b0);
    step("pc_wrap",  1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 5'd1,  2'b01, 32'h0000_0055, 32'd0,         32'd0,         1'b0);
    step("x0",       1'b1, 1'b0, 1'b0, 32'h0000_0200, 5'd0,  2'b00, 32'h0000_0077, 32'd0,         32'd0,         1'b0);
    step("store",    1'b1, 1'b0, 1'b0, 32'h0000_0204, 5'd9,  2'b00, 32'h0000_0088, 32'd0,         32'd0,         1'b1);
    step("bubble",   1'b0, 1'b0, 1'b0, 32'h0000_0208, 5'd10, 2'b00, 32'h0000_0099, 32'd0,         32'd0,         1'b0);
    step("flush",    1'b1, 1'b1, 1'b1, 32'h0000_020C, 5'd11, 2'b00, 32'h0000_00AA, 32'd0,         32'd0,         1'b0);
    step("flushbub", 1'b0, 1'b1, 1'b0, 32'h0000_0210, 5'd12, 2'b00, 32'h0000_00BB, 32'd0,         32'd0,         1'b0);
    step("postflsh", 1'b1, 1'b0, 1'b0, 32'h0000_0214, 5'd13, 2'b00, 32'h0000_00CC, 32'd0,         32'd0,         1'b0);
    step("halt",     1'b1, 1'b0, 1'b1, 32'h0000_0218, 5'd7,  2'b00, 32'h0000_00DD, 32'd0,         32'd0,         1'b0);
    for (int i = 0; i < 12; i++) begin
      step("halted", 1'b1, 1'b0, 1'b0, 32'h0000_0300 + 32'(i * 4), 5'(i + 2), 2'b00,
           32'h0000_1000 + 32'(i), 32'd0, 32'd0, 1'b0);
    end

    do_reset("rst_halt");
    step("post_rst", 1'b1, 1'b0, 1'b0, 32'h0000_0400, 5'd3,  2'b00, 32'hCAFE_F00D, 32'd0,         32'd0,         1'b0);
    step("post_rs2", 1'b1, 1'b0, 1'b0, 32'h0000_0404, 5'd4,  2'b11, 32'd0,         32'd0,         32'h1234_5000, 1'b0);
    step("drain",    1'b0, 1'b0, 1'b0, 32'h0000_0408, 5'd0,  2'b00, 32'd0,         32'd0,         32'd0,         1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the memory stage of the pipelined RV32 core.
- Registers the memory-stage results in a MEM/WB pipeline register and selects the writeback value.
- Drives the register-file write port and the WB-to-EX forwarding bus.
- Owns the sticky halt state machine and the retired-instruction counter.

Parameters:
- INSTRET_WIDTH, 32, width of the retired-instruction counter (wraps modulo 2^INSTRET_WIDTH).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in_wb  input  1  memory stage presents a real instruction this cycle.
- flush_in_wb  input  1  squash the instruction being latched this edge.
- halt_in_wb  input  1  halt flag from the memory stage.
- PC_in_wb  input  32  instruction PC.
- Instr_in_wb  input  32  instruction word; rd is bits [11:7].
- ALUOutput_in_wb  input  32  ALU result.
- LoadExtended_in_wb  input  32  extended load data.
- Imm_in_wb  input  32  decoded immediate (LUI).
- WBSel_in_wb  input  2  00 ALU, 01 PC+4, 10 Mem, 11 Imm.
- RWrEn_in_wb  input  1  register write enable, active-low (0 = write).
- RWrEn_out_wb  output  1  regfile write enable, active-low.
- Rdst_out_wb  output  5  regfile write address.
- RWrdata_out_wb  output  32  regfile write data.
- fwd_valid_out_wb  output  1  forwarding entry valid (active-high).
- fwd_rd_out_wb  output  5  forwarding destination.
- fwd_data_out_wb  output  32  forwarding data.
- halt_out_wb  output  1  core halted.
- instret_out_wb  output  INSTRET_WIDTH  count of retired instructions.

Behaviour:
- Pipeline register
  - On each posedge, when not in HALTED, all *_in_wb fields are latched.
  - valid_q <= valid_in_wb & ~flush_in_wb.
  - halt_q <= halt_in_wb & valid_in_wb & ~flush_in_wb. A squashed instruction never halts.
  - In HALTED the register is frozen and inputs are ignored.
- Latency: inputs sampled at edge N drive the write port and forwarding outputs combinationally during cycle N+1 (1-cycle latency).
- Writeback mux (on registered fields):
  - 00 → ALUOutput.
  - 01 → PC+4, 32-bit wrap (0xFFFFFFFC → 0x00000000).
  - 10 → LoadExtended.
  - 11 → Imm.
- Write qualifier: we = valid_q & ~halt_q & (RWrEn_q == 0) & (rd_q != 0) & (state == RUN).
  - RWrEn_out_wb = ~we.
  - Rdst_out_wb = rd_q.
  - RWrdata_out_wb = mux result.
  - Writes to x0 are always suppressed.
- Forwarding: fwd_valid_out_wb = we; fwd_rd_out_wb = rd_q; fwd_data_out_wb = mux result.
  - When fwd_valid_out_wb is 0, rd and data are don't-care but must be stable (no X).
- State machine, 2 states:
  - RUN → HALTED at the edge where valid_q & halt_q.
  - HALTED holds until rst; there is no other exit.
- halt_out_wb = (state == HALTED) | (valid_q & halt_q).
  - Asserts combinationally in the same cycle the halting instruction occupies WB.
  - The halting instruction performs no register write and is not counted.
- instret: increments by 1 at each edge where valid_q & ~halt_q & state == RUN. This counts every retired instruction, including stores and branches, whatever RWrEn is. Wraps at 2^INSTRET_WIDTH.
- Reset (synchronous, dominates all other inputs):
  - valid_q = 0, halt_q = 0, state = RUN, instret = 0.
  - All other registered fields = 0.
  - Resulting outputs: RWrEn_out_wb = 1, Rdst_out_wb = 0, RWrdata_out_wb = 0, fwd_valid_out_wb = 0, fwd_rd_out_wb = 0, fwd_data_out_wb = 0, halt_out_wb = 0, instret_out_wb = 0.
  - Reset while HALTED returns to RUN.
- Simultaneous events:
  - flush_in_wb with halt_in_wb → flush wins; no halt.
  - flush_in_wb with valid_in_wb = 0 → bubble.
  - Inputs arriving during the cycle halt_out_wb first rises are ignored from the next edge on.

Test Plan:
- ALU writeback: valid = 1, Instr rd = 5, WBSel = 00, ALUOutput = 0x1234, RWrEn = 0 → next cycle RWrEn_out_wb = 0, Rdst = 5, data = 0x1234, fwd_valid = 1. After the following edge, instret = 1.
- Select coverage: PC = 0x100 with WBSel = 01 → 0x104. WBSel = 10 with LoadExtended = 0xFFFFFF80 → 0xFFFFFF80. WBSel = 11 with Imm = 0xABCDE000 → 0xABCDE000. PC = 0xFFFFFFFC with WBSel = 01 → 0x00000000.
- x0 and disabled writes: rd = 0 with RWrEn = 0 → RWrEn_out_wb = 1, fwd_valid = 0, instret still increments. A store with RWrEn = 1 → no write, instret increments.
- Flush: valid = 1, halt = 1, flush = 1 → no halt, no write, instret unchanged. The next valid instruction writes normally.
- Halt: valid = 1, halt = 1, rd = 7 → halt_out_wb = 1 in the WB cycle, no write, instret unchanged. Subsequent valid ALU instructions produce no writes and halt_out_wb stays 1 for 10+ cycles.
- Reset mid-halt: assert rst for 1 cycle while HALTED → all outputs at reset values next cycle, state RUN. A new instruction writes back normally.
